// File: rtl/lvds_word_aligner.sv
// lvds_word_aligner: K28.5 comma search, word alignment and sync-acquisition
// controller between the LVDS deserializer and the 8b/10b decoder. Alignment
// uses an internal barrel shifter (SLIP_MODE=0) or external bitslip pulses
// (SLIP_MODE=1). Sync status uses lock/loss hysteresis.
module lvds_word_aligner #(
   parameter int SLIP_MODE     = 0,
   parameter int SLIP_SETTLE   = 8,
   parameter int LOCK_COMMAS   = 3,
   parameter int LOSS_ERRS     = 4,
   parameter int COMMA_TIMEOUT = 4096
) (
   input  logic       i_Clk,
   input  logic       i_ARst,
   input  logic [9:0] i10_RawData,
   input  logic       i_CodeErr,
   output logic [9:0] o10_AlignedData,
   output logic       o_Synced,
   output logic       o_BitSlip,
   output logic [3:0] o4_SlipPos,
   output logic       o_CommaAligned
);

   localparam int TO_W = $clog2(COMMA_TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST   = TO_W'(COMMA_TIMEOUT - 1);
   localparam logic [3:0]      LOCK_LIM  = 4'(LOCK_COMMAS);
   localparam logic [3:0]      LOSS_LIM  = 4'(LOSS_ERRS);
   localparam logic [7:0]      SETTLE_LD = 8'(SLIP_SETTLE);

   typedef enum logic [1:0] {HUNT, SLIPWAIT, VERIFY, SYNC} alignState_e;

   alignState_e curState, nextState;

   logic [9:0]      r10_Prev;
   logic [9:0]      alignedWord_p1;
   logic [19:0]     window;
   logic [19:0]     alignedShift;
   logic [19:0]     probe;
   logic            commaFound;
   logic [3:0]      commaPos;
   logic [3:0]      alignPos;
   logic            alignedComma;
   logic            misComma;
   logic            timeout;

   logic [3:0]      slipPos, slipPosNext;
   logic [3:0]      lockCnt, lockCntNext;
   logic [3:0]      errCnt, errCntNext;
   logic [TO_W-1:0] toCnt, toCntNext;
   logic [7:0]      settleCnt, settleCntNext;
   logic            slipPulse;
   logic            commaPulse;

   function automatic logic isComma(input logic [6:0] seg);
      return (seg == 7'b0011111) || (seg == 7'b1100000);
   endfunction

   function automatic logic [3:0] satInc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

   function automatic logic [TO_W-1:0] satIncTo(input logic [TO_W-1:0] v);
      return (v == {TO_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   function automatic logic [7:0] satDec8(input logic [7:0] v);
      return (v == 8'd0) ? v : v - 8'd1;
   endfunction

   // Stage p0: the previous raw word forms the upper half of the 20-bit window
   always_ff @(posedge i_Clk or posedge i_ARst) begin
      if (i_ARst) r10_Prev <= '0;
      else        r10_Prev <= i10_RawData;
   end

   assign window       = {r10_Prev, i10_RawData};
   assign alignedShift = window << slipPos;

   // Comma scan over all ten offsets; the lowest matching offset wins
   always_comb begin
      commaFound = 1'b0;
      commaPos   = '0;
      probe      = '0;
      for (int k = 9; k >= 0; k--) begin
         probe = window << k;
         if (isComma(probe[19:13])) begin
            commaFound = 1'b1;
            commaPos   = 4'(k);
         end
      end
   end

   assign alignPos     = (SLIP_MODE != 0) ? 4'd0 : slipPos;
   assign alignedComma = commaFound && (commaPos == alignPos);
   assign misComma     = commaFound && (commaPos != alignPos);
   assign timeout      = (toCnt == TO_LAST) && !alignedComma;

   // Next-state and counter decisions for the acquisition FSM
   always_comb begin
      nextState     = curState;
      slipPosNext   = slipPos;
      lockCntNext   = lockCnt;
      errCntNext    = errCnt;
      settleCntNext = settleCnt;
      toCntNext     = toCnt;
      slipPulse     = 1'b0;
      commaPulse    = 1'b0;
      case (curState)
         HUNT: begin
            if (commaFound) begin
               if (SLIP_MODE == 0) begin
                  slipPosNext = commaPos;
                  lockCntNext = 4'd1;
                  nextState   = VERIFY;
               end else if (commaPos == 4'd0) begin
                  lockCntNext = 4'd1;
                  nextState   = VERIFY;
               end else begin
                  slipPulse     = 1'b1;
                  settleCntNext = SETTLE_LD;
                  nextState     = SLIPWAIT;
               end
            end
         end
         SLIPWAIT: begin
            settleCntNext = satDec8(settleCnt);
            if (settleCntNext == 8'd0) nextState = HUNT;
         end
         VERIFY: begin
            commaPulse = alignedComma;
            if (alignedComma) begin
               lockCntNext = satInc4(lockCnt);
               if (lockCntNext >= LOCK_LIM) nextState = SYNC;
            end else if (misComma) begin
               lockCntNext = '0;
               nextState   = HUNT;
            end else if (timeout) begin
               nextState = HUNT;
            end
         end
         SYNC: begin
            commaPulse = alignedComma;
            if (alignedComma)                errCntNext = '0;
            else if (i_CodeErr || misComma)  errCntNext = satInc4(errCnt);
            if (!alignedComma && ((errCntNext >= LOSS_LIM) || timeout)) begin
               errCntNext = '0;
               nextState  = HUNT;
            end
         end
         default: nextState = HUNT;
      endcase
      // Comma timeout only runs while waiting for aligned commas in one state
      if ((nextState != curState) || alignedComma ||
          !((curState == VERIFY) || (curState == SYNC)))
         toCntNext = '0;
      else
         toCntNext = satIncTo(toCnt);
   end

   // Stage p1: state, offset, counters and registered control pulses
   always_ff @(posedge i_Clk or posedge i_ARst) begin
      if (i_ARst) begin
         curState       <= HUNT;
         slipPos        <= '0;
         lockCnt        <= '0;
         errCnt         <= '0;
         toCnt          <= '0;
         settleCnt      <= '0;
         o_BitSlip      <= 1'b0;
         o_CommaAligned <= 1'b0;
      end else begin
         curState       <= nextState;
         slipPos        <= slipPosNext;
         lockCnt        <= lockCntNext;
         errCnt         <= errCntNext;
         toCnt          <= toCntNext;
         settleCnt      <= settleCntNext;
         o_BitSlip      <= slipPulse;
         o_CommaAligned <= commaPulse;
      end
   end

   // Stage p1: aligned word extracted from the window at the current offset
   always_ff @(posedge i_Clk or posedge i_ARst) begin
      if (i_ARst) alignedWord_p1 <= '0;
      else        alignedWord_p1 <= alignedShift[19:10];
   end

   assign o10_AlignedData = alignedWord_p1;
   assign o_Synced        = (curState == SYNC);
   assign o4_SlipPos      = slipPos;

endmodule
